// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: opcode/funct codes, writeback select and load type encodings
package wb_stage_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] JR_FUNCT    = 6'h08;
    localparam logic [5:0] JALR_FUNCT  = 6'h09;
    localparam logic [5:0] MFHI_FUNCT  = 6'h10;
    localparam logic [5:0] MTHI_FUNCT  = 6'h11;
    localparam logic [5:0] MFLO_FUNCT  = 6'h12;
    localparam logic [5:0] MTLO_FUNCT  = 6'h13;
    localparam logic [5:0] MULT_FUNCT  = 6'h18;
    localparam logic [5:0] MULTU_FUNCT = 6'h19;
    localparam logic [5:0] DIV_FUNCT   = 6'h1a;
    localparam logic [5:0] DIVU_FUNCT  = 6'h1b;
    typedef enum logic [2:0] {SEL_ALU = 3'd0, SEL_MEM = 3'd1, SEL_LINK = 3'd2, SEL_HI = 3'd3, SEL_LO = 3'd4} wd_sel_e;
    typedef enum logic [2:0] {LD_W, LD_H, LD_HU, LD_B, LD_BU} ld_type_e;
endpackage

// File: rtl/wb_stage_load_ext.sv
// load_ext: byte/half extraction from an aligned word with sign or zero extension
module load_ext
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  ld_type_e          ld_type,
    output logic [DATA_W-1:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    // pick the addressed byte/half, then extend by load type; half ignores offset[0]
    always_comb begin
        b = word[{offset, 3'b000} +: 8];
        h = word[{offset[1], 4'b0000} +: 16];
        result = ld_type == LD_B  ? {{(DATA_W-8){b[7]}}, b} :
                 ld_type == LD_BU ? {{(DATA_W-8){1'b0}}, b} :
                 ld_type == LD_H  ? {{(DATA_W-16){h[15]}}, h} :
                 ld_type == LD_HU ? {{(DATA_W-16){1'b0}}, h} : word;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: M/W pipeline register, GRF write decode and writeback select (trace: WB_TRACE_EN)
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PC_LINK_OFF = 8,
    parameter int RA_ADDR     = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_en,
    input  logic              W_clr,
    input  logic [31:0]       M_Instr,
    input  logic [31:0]       M_PC,
    input  logic [DATA_W-1:0] M_ALUResult,
    input  logic [DATA_W-1:0] M_DMRD,
    input  logic [DATA_W-1:0] M_HI,
    input  logic [DATA_W-1:0] M_LO,
    output logic [31:0]       W_Instr,
    output logic [31:0]       W_PC,
    output logic [DATA_W-1:0] W_WD,
    output logic [4:0]        W_A3,
    output logic              W_WE,
    output logic              W_valid
);
    logic [DATA_W-1:0] alu, dmrd, hi, lo, ld_data;
    logic [5:0]        op, fn;
    logic              is_r, r_wr, is_load, is_ialu, is_jal, writer;
    logic [31:0]       link;
    ld_type_e          ld_type;
    wd_sel_e           sel;
    // pipeline register: reset and flush both insert a bubble, clear beats load
    always_ff @(posedge clk) begin
        if (reset || W_clr) begin
            W_Instr <= '0;
            W_PC    <= '0;
            alu     <= '0;
            dmrd    <= '0;
            hi      <= '0;
            lo      <= '0;
            W_valid <= 1'b0;
        end else if (W_en) begin
            W_Instr <= M_Instr;
            W_PC    <= M_PC;
            alu     <= M_ALUResult;
            dmrd    <= M_DMRD;
            hi      <= M_HI;
            lo      <= M_LO;
            W_valid <= 1'b1;
        end
    end
    // decode the stored instruction into write address, enable and data select
    always_comb begin
        op      = W_Instr[31:26];
        fn      = W_Instr[5:0];
        is_r    = op == OP_RTYPE;
        r_wr    = is_r && !(fn inside {JR_FUNCT, MTHI_FUNCT, MTLO_FUNCT, MULT_FUNCT, MULTU_FUNCT, DIV_FUNCT, DIVU_FUNCT});
        is_load = op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
        is_ialu = op inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI};
        is_jal  = op == OP_JAL;
        writer  = r_wr || is_load || is_ialu || is_jal;
        ld_type = op == OP_LB ? LD_B : op == OP_LBU ? LD_BU : op == OP_LH ? LD_H : op == OP_LHU ? LD_HU : LD_W;
        W_A3    = r_wr ? W_Instr[15:11] : (is_load || is_ialu) ? W_Instr[20:16] : is_jal ? 5'(RA_ADDR) : 5'd0;
        W_WE    = W_valid && writer && W_A3 != 5'd0;
        sel     = is_load ? SEL_MEM :
                  (is_jal || (is_r && fn == JALR_FUNCT)) ? SEL_LINK :
                  (is_r && fn == MFHI_FUNCT) ? SEL_HI :
                  (is_r && fn == MFLO_FUNCT) ? SEL_LO : SEL_ALU;
        link    = W_PC + 32'(PC_LINK_OFF);
        W_WD    = sel == SEL_MEM  ? ld_data :
                  sel == SEL_LINK ? DATA_W'(link) :
                  sel == SEL_HI   ? hi :
                  sel == SEL_LO   ? lo : alu;
    end
    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .word   (dmrd),
        .offset (alu[1:0]),
        .ld_type(ld_type),
        .result (ld_data)
    );
`ifdef WB_TRACE_EN
    // judge-format trace of every committed GRF write
    always @(posedge clk) begin
        if (!reset && W_WE) $display("@%h: $%d <= %h", W_PC, W_A3, W_WD);
    end
`else
`endif
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Registered writeback stage for the 5-stage MIPS pipeline. It holds the M/W pipeline register and extends load data by byte offset.
- It selects the GRF write value from ALU, memory, PC+8, HI or LO, and generates GRF write address and enable.
- It exports W-stage forwarding info (address, data valid) to the hazard unit.

Parameters:
- DATA_W, 32, datapath width; must be ≥32 and a multiple of 8.
- PC_LINK_OFF, 8, offset added to PC for jal/jalr link value.
- RA_ADDR, 31, GRF index written by jal.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; clears the W register
- W_en  in  1  load enable; 0 = hold (stall)
- W_clr  in  1  flush; inserts a bubble on the next edge
- M_Instr  in  32  instruction leaving M
- M_PC  in  32  PC of M instruction
- M_ALUResult  in  DATA_W  ALU result / memory address
- M_DMRD  in  DATA_W  raw aligned word read from DM
- M_HI  in  DATA_W  HI value at M
- M_LO  in  DATA_W  LO value at M
- W_Instr  out  32  registered instruction
- W_PC  out  32  registered PC
- W_WD  out  DATA_W  GRF write data
- W_A3  out  5  GRF write address
- W_WE  out  1  GRF write enable
- W_valid  out  1  W holds a real, non-bubble instruction

Behaviour:
- Register update on posedge clk, priority reset > W_clr > W_en.
  - reset or W_clr: all stored fields become 0 and valid becomes 0, so W_Instr=0 (nop) and W_WE=0.
  - W_en=1: capture all M_* inputs; valid becomes 1.
  - W_en=0: hold all fields.
- Latency: one cycle from M inputs to W outputs; W_WD/W_A3/W_WE are combinational from the stored fields.
- Reset values: W_Instr=0, W_PC=0, W_WD=0, W_A3=0, W_WE=0, W_valid=0.
- Decode from stored opcode/funct:
  - lw/lh/lhu/lb/lbu: opcodes 23,21,25,20,24 (hex).
  - jal: opcode 03.
  - jalr, mfhi, mflo: R-type (op 00) with funct 09, 10, 12 (hex).
  - Remaining R-type ALU ops write rd; I-type ALU ops (addi, andi, ori, lui, slti) write rt.
  - Stores, branches, j, jr, mult/div, mthi/mtlo: no write.
- W_A3:
  - rd for R-type writers (including jalr, mfhi, mflo).
  - rt for loads and I-type ALU ops.
  - RA_ADDR for jal.
  - 0 otherwise.
- W_WE = W_valid & writer & (W_A3 != 0). Writes to $0 are always suppressed.
- Load extension, byte offset o = stored ALUResult[1:0]:
  - lb/lbu: byte o (bits 8o+7:8o), sign- or zero-extended to DATA_W.
  - lh/lhu: half o[1] (o[0] ignored; alignment is checked upstream), sign- or zero-extended.
  - lw: full word.
- W_WD select:
  - load: extended data.
  - jal/jalr: PC + PC_LINK_OFF, modulo 2^32, zero-extended.
  - mfhi: HI.
  - mflo: LO.
  - else: ALUResult.
  - When W_WE=0, W_WD still shows the selected value; the GRF ignores it.
- Simultaneous W_clr and W_en: the clear wins.
- Reset asserted while stalled: the clear wins.

Optional Feature:
- Macro: WB_TRACE_EN.
- Defined: on each posedge where W_WE=1 and reset=0, print "@%h: $%d <= %h" with W_PC, W_A3, W_WD. This is the course judge format. Simulation-only, no synthesis impact.
- Undefined: no display code is compiled; functionality is identical.

Decomposition:
- Shared constants header: opcode/funct codes (LW, LH, LHU, LB, LBU, JAL, JALR_FUNCT, MFHI_FUNCT, MFLO_FUNCT, etc.) and the WD-select encoding (ALU=0, MEM=1, LINK=2, HI=3, LO=4).
- One sub-module, load_ext: combinational byte/half extraction and sign/zero extension. Inputs: word, offset, load type. Output: DATA_W result.
- The register, decode, and select logic stay in wb_stage.

Test Plan:
- lb, M_DMRD=0x80FF7F01, ALUResult=...03 → W_WD=0xFFFFFF80, W_A3=rt, W_WE=1. Repeat with lbu → 0x00000080.
- lh with offset 2 on 0x8001FFFF → 0xFFFF8001; lhu at offset 0 → 0x0000FFFF.
- jal at M_PC=0x00003010 → next cycle W_A3=31, W_WD=0x00003018, W_WE=1. jalr with rd=5 → W_A3=5, same link value.
- mfhi rd=8 with HI=0xDEADBEEF → W_WD=0xDEADBEEF. addu with rd=0 → W_WE=0.
- Stall then flush: W_en=0 for 2 cycles → outputs frozen. Then W_clr=1 together with W_en=1 → W_Instr=0, W_WE=0, W_valid=0.
- Reset mid-stream: assert reset for one edge while a valid lw is held → all outputs 0. The next enabled edge resumes capture normally.
